// File: rtl/tinyalu_pkg.sv
// -----------------------------------------------------------------------------
// tinyalu_pkg
//  Shared types for the TinyALU responder.
//   - operation_t      : op encoding, shared with the BFM
//   - tinyalu_state_t  : responder FSM states
//   - is_single_cycle  : true for ops finished by the one-cycle ALU mux
// -----------------------------------------------------------------------------
package tinyalu_pkg;

    localparam int OP_W  = 3;
    localparam int CNT_W = 4;

    typedef enum logic [OP_W-1:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MUL      = 2'b01,
        WAIT_REL = 2'b10
    } tinyalu_state_t;

    // add/and/xor complete in one cycle; everything else does not
    function automatic logic is_single_cycle(input logic [OP_W-1:0] op);
        logic r;
        case (op)
            add_op, and_op, xor_op: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// -----------------------------------------------------------------------------
// tinyalu_mul_pipe
//  Multiplier pipeline with MUL_LATENCY-1 register stages. The full-width
//  product is formed when the operands enter and then shifted along with a
//  valid bit, so out_valid rises in the cycle before the top registers done.
//  With MUL_LATENCY=1 the path is purely combinational.
// Ports:
//  clk, reset  : clock and synchronous active-high reset
//  in_valid    : operands a/b accepted this cycle
//  flush       : clears every valid bit (abort)
//  a, b        : unsigned operands, DATA_W bits
//  out_valid   : product is valid this cycle
//  product     : 2*DATA_W-bit unsigned product
// -----------------------------------------------------------------------------
module tinyalu_mul_pipe #(
    parameter int DATA_W      = 8,
    parameter int MUL_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  out_valid,
    output logic [2*DATA_W-1:0]   product
);

    localparam int RES_W  = 2 * DATA_W;
    localparam int STAGES = MUL_LATENCY - 1;

    generate
        if (STAGES == 0) begin : g_comb
            assign out_valid = in_valid & ~flush & ~reset;
            assign product   = RES_W'(a) * RES_W'(b);
        end else begin : g_pipe
            logic [STAGES-1:0] valid_q;
            logic [STAGES-1:0] valid_d;
            logic [RES_W-1:0]  prod_q [STAGES];
            logic [RES_W-1:0]  prod_d [STAGES];

            // shift valid bits and products one stage per cycle; flush kills all
            always_comb begin
                valid_d[0] = in_valid & ~flush;
                prod_d[0]  = RES_W'(a) * RES_W'(b);
                for (int i = 1; i < STAGES; i++) begin
                    valid_d[i] = valid_q[i-1] & ~flush;
                    prod_d[i]  = prod_q[i-1];
                end
            end

            // pipeline stage registers
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= {STAGES{1'b0}};
                    for (int i = 0; i < STAGES; i++) begin
                        prod_q[i] <= {RES_W{1'b0}};
                    end
                end else begin
                    valid_q <= valid_d;
                    for (int i = 0; i < STAGES; i++) begin
                        prod_q[i] <= prod_d[i];
                    end
                end
            end

            assign out_valid = valid_q[STAGES-1];
            assign product   = prod_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/tinyalu_responder.sv
// -----------------------------------------------------------------------------
// tinyalu_responder
//  Responder side of the TinyALU start/done handshake. Samples A/B/op when
//  start is seen in IDLE, returns add/and/xor one cycle later and mul after
//  MUL_LATENCY cycles, then waits in WAIT_REL until start drops so each start
//  assertion yields exactly one done pulse.
// Ports:
//  clk     : clock, all state on posedge
//  reset   : synchronous active-high reset, highest priority
//  A, B    : unsigned operands, DATA_W bits
//  op      : operation_t encoding (101/110 behave as no_op)
//  start   : request level, held by initiator until done
//  done    : one-cycle pulse, result valid in the same cycle
//  result  : last result, 2*DATA_W bits, held until the next done
// -----------------------------------------------------------------------------
module tinyalu_responder
    import tinyalu_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int MUL_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     A,
    input  logic [DATA_W-1:0]     B,
    input  logic [OP_W-1:0]       op,
    input  logic                  start,
    output logic                  done,
    output logic [2*DATA_W-1:0]   result
);

    localparam int RES_W = 2 * DATA_W;
    // counter counts the MUL-state cycles still needed after entry
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (MUL_LATENCY >= 2) ? CNT_W'(MUL_LATENCY - 2) : {CNT_W{1'b0}};

    tinyalu_state_t     state_q, state_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               mul_start_s;
    logic               mul_flush_s;
    logic               mul_valid_s;
    logic [RES_W-1:0]   mul_product_s;
    logic [RES_W-1:0]   alu_result_s;

    // pipe control kept outside the FSM block so the MUL_LATENCY=1
    // combinational return path does not loop through it
    assign mul_start_s = (state_q == IDLE) && start && (op == mul_op);
    assign mul_flush_s = (state_q == MUL) && !start;

    tinyalu_mul_pipe #(
        .DATA_W      (DATA_W),
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (mul_start_s),
        .flush     (mul_flush_s),
        .a         (A),
        .b         (B),
        .out_valid (mul_valid_s),
        .product   (mul_product_s)
    );

    // single-cycle ALU, operands zero-extended to the result width
    always_comb begin
        alu_result_s = {RES_W{1'b0}};
        case (op)
            add_op:  alu_result_s = RES_W'(A) + RES_W'(B);
            and_op:  alu_result_s = RES_W'(A & B);
            xor_op:  alu_result_s = RES_W'(A ^ B);
            default: alu_result_s = {RES_W{1'b0}};
        endcase
    end

    // FSM next state, result/done next values and mul counter
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start && is_single_cycle(op)) begin
                    result_d = alu_result_s;
                    done_d   = 1'b1;
                    state_d  = WAIT_REL;
                end else if (mul_start_s) begin
                    if (mul_valid_s) begin
                        result_d = mul_product_s;
                        done_d   = 1'b1;
                        state_d  = WAIT_REL;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = MUL;
                    end
                end else begin
                    // no_op, rst_op, illegal encodings or no request
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (!start) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = IDLE;
                end else if (mul_valid_s && (cnt_q == {CNT_W{1'b0}})) begin
                    result_d = mul_product_s;
                    done_d   = 1'b1;
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = WAIT_REL;
                end else if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = MUL;
                end else begin
                    state_d = MUL;
                end
            end
            WAIT_REL: begin
                if (!start) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_REL;
                end
            end
            default: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = IDLE;
            end
        endcase
    end

    // state, result, done and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= {RES_W{1'b0}};
            done_q   <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_tinyalu_responder.sv
// -----------------------------------------------------------------------------
// tb_tinyalu_responder
//  Directed bench for tinyalu_responder (DATA_W=8, MUL_LATENCY=3).
// -----------------------------------------------------------------------------
module tb_tinyalu_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tinyalu_responder #(
        .DATA_W      (8),
        .MUL_LATENCY (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .op     (op),
        .start  (start),
        .done   (done),
        .result (result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // raise start and measure cycles until done (bounded); start stays high
    task automatic run_req(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                           output int lat, output logic [15:0] res);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        lat   = -1;
        res   = 16'h0000;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (done === 1'b1) begin
                lat = c;
                res = result;
                break;
            end
        end
    endtask

    task automatic release_req();
        start = 1'b0;
        tick();
    endtask

    task automatic count_done(input int n, output int pulses);
        pulses = 0;
        for (int c = 0; c < n; c++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        A     = 8'h00;
        B     = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        checks++;
        if (result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_result: got %h want 0000", result);
        end
    endtask

    task automatic test_add();
        int lat;
        logic [15:0] res;
        run_req(3'b001, 8'hFF, 8'hFF, lat, res);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL add_latency: got %0d want 1", lat);
        end
        checks++;
        if (res !== 16'h01FE) begin
            errors++;
            $display("FAIL add_result: got %h want 01FE", res);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL add_done_pulse: done still %b after one cycle, want 0", done);
        end
        release_req();
    endtask

    task automatic test_logic();
        int lat;
        int p;
        logic [15:0] res;
        run_req(3'b010, 8'hF0, 8'h3C, lat, res);
        checks++;
        if (lat !== 1 || res !== 16'h0030) begin
            errors++;
            $display("FAIL and_op: got lat %0d res %h want lat 1 res 0030", lat, res);
        end
        count_done(3, p);
        checks++;
        if (p !== 0) begin
            errors++;
            $display("FAIL and_single_done: got %0d extra pulses want 0", p);
        end
        release_req();
        run_req(3'b011, 8'hAA, 8'hFF, lat, res);
        checks++;
        if (lat !== 1 || res !== 16'h0055) begin
            errors++;
            $display("FAIL xor_op: got lat %0d res %h want lat 1 res 0055", lat, res);
        end
        count_done(3, p);
        checks++;
        if (p !== 0) begin
            errors++;
            $display("FAIL xor_single_done: got %0d extra pulses want 0", p);
        end
        release_req();
    endtask

    task automatic test_mul();
        int lat;
        logic [15:0] res;
        run_req(3'b100, 8'hFF, 8'hFF, lat, res);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL mul_latency: got %0d want 3", lat);
        end
        checks++;
        if (res !== 16'hFE01) begin
            errors++;
            $display("FAIL mul_result: got %h want FE01", res);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL mul_done_pulse: done %b want 0", done);
        end
        release_req();
        run_req(3'b100, 8'h00, 8'h7B, lat, res);
        checks++;
        if (lat !== 3 || res !== 16'h0000) begin
            errors++;
            $display("FAIL mul_zero: got lat %0d res %h want lat 3 res 0000", lat, res);
        end
        release_req();
    endtask

    task automatic test_back_to_back();
        int lat;
        int p;
        logic [15:0] res;
        run_req(3'b001, 8'h01, 8'h02, lat, res);
        checks++;
        if (lat !== 1 || res !== 16'h0003) begin
            errors++;
            $display("FAIL held_first: got lat %0d res %h want lat 1 res 0003", lat, res);
        end
        count_done(10, p);
        checks++;
        if (p !== 0) begin
            errors++;
            $display("FAIL held_no_second_done: got %0d pulses want 0", p);
        end
        checks++;
        if (result !== 16'h0003) begin
            errors++;
            $display("FAIL held_result: got %h want 0003", result);
        end
        release_req();
        run_req(3'b001, 8'h05, 8'h06, lat, res);
        checks++;
        if (lat !== 1 || res !== 16'h000B) begin
            errors++;
            $display("FAIL rerequest: got lat %0d res %h want lat 1 res 000B", lat, res);
        end
        release_req();
    endtask

    task automatic test_no_done();
        logic [2:0] ops [4];
        int lat;
        int p;
        logic [15:0] res;
        ops[0] = 3'b000;
        ops[1] = 3'b101;
        ops[2] = 3'b110;
        ops[3] = 3'b111;
        run_req(3'b011, 8'hAA, 8'hFF, lat, res);
        release_req();
        for (int k = 0; k < 4; k++) begin
            op    = ops[k];
            A     = 8'h12;
            B     = 8'h34;
            start = 1'b1;
            count_done(5, p);
            start = 1'b0;
            tick();
            checks++;
            if (p !== 0) begin
                errors++;
                $display("FAIL nodone_op%b: got %0d pulses want 0", ops[k], p);
            end
            checks++;
            if (result !== 16'h0055) begin
                errors++;
                $display("FAIL nodone_result_op%b: got %h want 0055", ops[k], result);
            end
        end
        run_req(3'b001, 8'h01, 8'h01, lat, res);
        checks++;
        if (lat !== 1 || res !== 16'h0002) begin
            errors++;
            $display("FAIL nodone_still_idle: got lat %0d res %h want lat 1 res 0002", lat, res);
        end
        release_req();
    endtask

    task automatic test_mul_disrupt();
        int lat;
        int p;
        logic [15:0] res;
        // reset one cycle into a multiply
        op    = 3'b100;
        A     = 8'h10;
        B     = 8'h10;
        start = 1'b1;
        tick();
        reset = 1'b1;
        start = 1'b0;
        tick();
        reset = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mul_done: got %b want 0", done);
        end
        count_done(5, p);
        checks++;
        if (p !== 0) begin
            errors++;
            $display("FAIL reset_mid_mul_pulses: got %0d want 0", p);
        end
        checks++;
        if (result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_mul_result: got %h want 0000", result);
        end
        run_req(3'b001, 8'h01, 8'h01, lat, res);
        checks++;
        if (lat !== 1 || res !== 16'h0002) begin
            errors++;
            $display("FAIL after_reset_add: got lat %0d res %h want lat 1 res 0002", lat, res);
        end
        release_req();
        // start dropped one cycle into a multiply
        op    = 3'b100;
        A     = 8'h10;
        B     = 8'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        count_done(5, p);
        checks++;
        if (p !== 0) begin
            errors++;
            $display("FAIL abort_mul_pulses: got %0d want 0", p);
        end
        checks++;
        if (result !== 16'h0002) begin
            errors++;
            $display("FAIL abort_mul_result: got %h want 0002", result);
        end
        run_req(3'b001, 8'h01, 8'h01, lat, res);
        checks++;
        if (lat !== 1 || res !== 16'h0002) begin
            errors++;
            $display("FAIL after_abort_add: got lat %0d res %h want lat 1 res 0002", lat, res);
        end
        release_req();
        run_req(3'b100, 8'h03, 8'h05, lat, res);
        checks++;
        if (lat !== 3 || res !== 16'h000F) begin
            errors++;
            $display("FAIL after_abort_mul: got lat %0d res %h want lat 3 res 000F", lat, res);
        end
        release_req();
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic();
        test_mul();
        test_back_to_back();
        test_no_done();
        test_mul_disrupt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
